icache_fill_controller: RTL

ICACHE_FILL_CONTROLLER -- requirements
Module: icache_fill_controller

---
 rtl/icache_fill_controller.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/icache_fill_controller.sv
// I$ line fill controller: takes one miss, bursts the line in from memory,
// writes data RAM beats, then the tag of a round-robin victim way.
module icache_fill_controller #(
  parameter int ICACHE_NUM_WAYS = 4,
  parameter int ICACHE_NUM_SETS = 64,
  parameter int LINE_WORDS      = 8,
  localparam int SB = $clog2(ICACHE_NUM_SETS),
  localparam int OB = $clog2(LINE_WORDS) + 2,
  localparam int TB = 32 - SB - OB,
  localparam int CB = OB - 2,
  localparam int LB = 32 - OB,
  localparam int WB = (ICACHE_NUM_WAYS > 1) ? $clog2(ICACHE_NUM_WAYS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       miss_valid,
  input  logic [31:0]                miss_addr,
  input  logic                       invalidate,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [31:0]                mem_req_addr,
  input  logic                       mem_rsp_valid,
  input  logic [31:0]                mem_rsp_data,
  output logic                       data_wr_en,
  output logic [WB-1:0]              data_wr_way,
  output logic [SB+OB-3:0]           data_wr_addr,
  output logic [31:0]                data_wr_data,
  output logic [ICACHE_NUM_WAYS-1:0] update_tag_en,
  output logic [SB-1:0]              update_tag_set,
  output logic [TB-1:0]              update_tag,
  output logic                       resume_fetch,
  output logic                       fsm_idle
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_FILL,
    S_TAG,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [LB-1:0]  r_line;
  logic [WB-1:0]  r_victim;
  logic [WB-1:0]  r_fill_way;
  logic [CB-1:0]  r_beat;
  logic           r_stale;

  logic           w_start;
  logic           w_req_fire;
  logic           w_beat;
  logic           w_last_beat;
  logic           w_unused;

  // Byte offset of the missing PC is irrelevant: whole line is fetched.
  assign w_unused    = ^miss_addr[OB-1:0];

  assign w_start     = (r_state == S_IDLE) && miss_valid;
  assign w_req_fire  = (r_state == S_REQ) && mem_req_ready;
  assign w_beat      = (r_state == S_FILL) && mem_rsp_valid;
  assign w_last_beat = (r_beat == CB'(LINE_WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (miss_valid) w_next = S_REQ;
      S_REQ:  if (mem_req_ready) w_next = S_FILL;
      S_FILL: if (mem_rsp_valid && w_last_beat) w_next = S_TAG;
      S_TAG:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_line     <= '0;
      r_fill_way <= '0;
    end else if (w_start) begin
      r_line     <= miss_addr[31:OB];
      r_fill_way <= r_victim;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat <= '0;
    end else if (w_req_fire) begin
      r_beat <= '0;
    end else if (w_beat) begin
      r_beat <= r_beat + CB'(1);
    end
  end

  // Stale marks a fill whose tag must not become valid after an invalidate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stale <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_stale <= 1'b0;
    end else if (invalidate) begin
      r_stale <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_victim <= '0;
    end else if (r_state == S_DONE) begin
      if (r_victim == WB'(ICACHE_NUM_WAYS - 1)) begin
        r_victim <= '0;
      end else begin
        r_victim <= r_victim + WB'(1);
      end
    end
  end

  always_comb begin
    mem_req_valid  = (r_state == S_REQ);
    mem_req_addr   = {r_line, {OB{1'b0}}};
    data_wr_en     = w_beat;
    data_wr_way    = r_fill_way;
    data_wr_addr   = {r_line[SB-1:0], r_beat};
    data_wr_data   = mem_rsp_data;
    update_tag_en  = '0;
    update_tag_set = r_line[SB-1:0];
    update_tag     = r_line[LB-1:SB];
    resume_fetch   = (r_state == S_DONE);
    fsm_idle       = (r_state == S_IDLE);
    if ((r_state == S_TAG) && !r_stale && !invalidate) begin
      update_tag_en = ICACHE_NUM_WAYS'(1) << r_fill_way;
    end
  end

endmodule
